program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 2: op-low cycles held after each accepted instruction, covering controller decode/execute.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_valid  input  1  load request, instruction on wr_data.
REQ-005 wr_data  input  20  instruction word [19:16] opcode, [15:8] operand B, [7:0] operand A.
REQ-006 wr_ready  output  1  sequencer accepts a load word this cycle.
REQ-007 clear  input  1  discard loaded program (count to 0).
REQ-008 start  input  1  begin issuing the loaded program.
REQ-009 abort  input  1  stop issuing, return to IDLE.
REQ-010 address  input  4  instruction address driven by the controller.
REQ-011 opcode  output  4  opcode of mem[address].
REQ-012 operand_b, operand_a  output  8 each  operands of mem[address].
REQ-013 op  output  1  instruction valid, offered to controller.
REQ-014 count  output  5  number of loaded instructions, 0..16.
REQ-015 busy  output  1  high in ISSUE or WAIT.
REQ-016 done  output  1  one-cycle pulse when program complete.

Function
REQ-017 Storage SHALL be 16 x 20-bit entries; contents SHALL not be reset.
REQ-018 States SHALL be IDLE, ISSUE, WAIT; reset state IDLE.
REQ-019 wr_ready SHALL equal (state==IDLE && count<16 && !clear).
REQ-020 wr_valid && wr_ready SHALL write mem[count] <= wr_data and increment count at the same edge.
REQ-021 wr_valid with count==16 SHALL be dropped; count saturates at 16, no wrap.
REQ-022 clear in IDLE SHALL set count to 0 next edge; clear outside IDLE SHALL be ignored.
REQ-023 clear and wr_valid in same cycle: clear wins, no write.
REQ-024 start in IDLE with count>0 SHALL enter ISSUE next edge, clear issued counter to 0, capture address into last_addr.
REQ-025 start in IDLE with count==0 SHALL pulse done next cycle and remain IDLE.
REQ-026 start and wr_valid in same IDLE cycle: write occurs, start honoured using the incremented count.
REQ-027 {opcode, operand_b, operand_a} SHALL be a combinational read of mem[address] in all states.
REQ-028 op SHALL be 1 only in ISSUE, 0 in IDLE and WAIT.
REQ-029 Acceptance SHALL be detected in ISSUE when address != last_addr; 15->0 wrap counts as acceptance.
REQ-030 On acceptance: issued counter +1, last_addr <= address, enter WAIT, gap counter loaded with GAP_CYCLES.
REQ-031 op SHALL drop in the cycle acceptance is detected (registered state, Moore op).
REQ-032 WAIT SHALL decrement gap counter each cycle; at 0, go to IDLE with done pulse if issued==count, else ISSUE.
REQ-033 ISSUE with no acceptance SHALL hold op high indefinitely; no timeout.
REQ-034 abort in ISSUE or WAIT SHALL go to IDLE next edge, op low, no done pulse; count kept.
REQ-035 abort, clear and start in IDLE: abort has no effect; clear beats start.
REQ-036 Width rules: issued and count 5-bit unsigned; comparisons unsigned, 16 issues allowed.

Reset
REQ-037 Reset SHALL force state IDLE, count 0, issued 0, last_addr 0, gap counter 0, op 0, done 0, busy 0, wr_ready 1.
REQ-038 Reset mid-ISSUE/WAIT SHALL take effect asynchronously; op low without waiting for clock.

Verification
REQ-039 Load 3 words 0x0_05_03, 0x2_01_02, 0x8_00_04, start, controller model at address 0 -> op high, opcode 0, operands B=0x05 A=0x03; three acceptances; done pulses once, count stays 3.
REQ-040 Load 16 words, 17th wr_valid -> wr_ready 0 at count 16, word dropped; run -> 16 acceptances, address wraps 15->0, done pulses.
REQ-041 Start with count 0 -> done pulse next cycle, op never asserted, busy never high.
REQ-042 Controller stalled (address constant) 50 cycles in ISSUE -> op held high, state unchanged; then abort -> IDLE next cycle, op 0, no done.
REQ-043 After acceptance with GAP_CYCLES=2 -> op low exactly 2 WAIT cycles then high again for next instruction.
REQ-044 Assert reset during WAIT of instruction 2 of 3 -> op 0, count 0, busy 0 immediately; wr_ready 1 after release.

Source files
------------

// File: rtl/program_sequencer.sv
// Program sequencer: holds up to 16 instruction words and offers them one at a time to a
// controller, which acknowledges each one by moving its address. A fixed gap follows each acknowledgement.
module program_sequencer #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [19:0] wr_data,
    output logic        wr_ready,
    input  logic        clear,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  address,
    output logic [3:0]  opcode,
    output logic [7:0]  operand_b,
    output logic [7:0]  operand_a,
    output logic        op,
    output logic [4:0]  count,
    output logic        busy,
    output logic        done
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         count_q, count_d;
    logic [4:0]         issued_q, issued_d;
    logic [3:0]         last_addr_q, last_addr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               done_q, done_d;
    logic [19:0]        mem_q [16];
    logic               wr_en;
    logic [4:0]         count_inc;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        wr_ready    = (state_q == IDLE) && (count_q < 5'd16) && !clear;
        wr_en       = wr_valid && wr_ready;
        count_inc   = wr_en ? count_q + 5'd1 : count_q;
        state_d     = state_q;
        count_d     = count_q;
        issued_d    = issued_q;
        last_addr_d = last_addr_q;
        gap_d       = gap_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = 5'd0;
                end else begin
                    count_d = count_inc;
                    // A word written in the same cycle as start counts towards the program.
                    if (start) begin
                        if (count_inc != 5'd0) begin
                            state_d     = ISSUE;
                            issued_d    = 5'd0;
                            last_addr_d = address;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (address != last_addr_q) begin
                    issued_d    = issued_q + 5'd1;
                    last_addr_d = address;
                    gap_d       = GAP_W'(GAP_CYCLES);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = (issued_q == count_q) ? IDLE : ISSUE;
                    done_d  = (issued_q == count_q);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            issued_q    <= 5'd0;
            last_addr_q <= 4'd0;
            gap_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            last_addr_q <= last_addr_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the instruction store has no reset; count_q alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q[3:0]] <= wr_data;
        end
    end

    assign {opcode, operand_b, operand_a} = mem_q[address];
    assign op    = (state_q == ISSUE);
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed programs, a controller model that steps the address
// on each offer, and a scoreboard that compares every offered instruction against the loaded words.
module tb_program_sequencer;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [19:0] wr_data;
    logic        wr_ready;
    logic        clear;
    logic        start;
    logic        abort;
    logic [3:0]  address;
    logic [3:0]  opcode;
    logic [7:0]  operand_b;
    logic [7:0]  operand_a;
    logic        op;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    int          total = 0;
    int          bad = 0;
    logic [19:0] exp_q[$];
    bit          ctrl_en = 1'b0;
    int          offers = 0;
    int          done_cnt = 0;

    program_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clear     (clear),
        .start     (start),
        .abort     (abort),
        .address   (address),
        .opcode    (opcode),
        .operand_b (operand_b),
        .operand_a (operand_a),
        .op        (op),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [19:0] w, input bit expect_offer);
        wr_valid = 1'b1;
        wr_data  = w;
        if (expect_offer) exp_q.push_back(w);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard monitor: each rising op is one offered instruction.
    initial begin : monitor
        bit          op_prev;
        bit          seen;
        int          low_run;
        logic [19:0] exp_w;
        op_prev = 1'b0;
        seen    = 1'b0;
        low_run = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b1) begin
                low_run = 0;
                seen    = 1'b0;
            end else if (op === 1'b0) begin
                low_run++;
            end
            if (op === 1'b1 && !op_prev) begin
                offers++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_offer: got=0x%0h want=none", {opcode, operand_b, operand_a});
                end else begin
                    exp_w = exp_q.pop_front();
                    check("offer", {12'h0, opcode, operand_b, operand_a}, {12'h0, exp_w});
                end
                if (seen) check("gap_cycles", low_run, GAP);
                seen    = 1'b1;
                low_run = 0;
            end
            op_prev = (op === 1'b1);
        end
    end

    // Controller model: acknowledges an offer by moving to the next address.
    initial begin : controller
        forever begin
            @(negedge clk);
            if (ctrl_en && op === 1'b1) begin
                #2;
                address = address + 4'd1;
            end
        end
    end

    initial begin : main
        int          d0;
        int          o0;
        int          high;
        bit          ok;
        bit          got;
        logic [19:0] w;

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 20'h0;
        clear    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        address  = 4'd0;

        repeat (2) sample();
        check("rst_op", 32'(op), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        step();
        reset = 1'b0;

        // Start with an empty program.
        d0 = done_cnt;
        pulse_start();
        sample();
        check("empty_done", 32'(done), 1);
        check("empty_busy", 32'(busy), 0);
        check("empty_op", 32'(op), 0);
        sample();
        check("empty_done_drop", 32'(done), 0);
        check("empty_done_count", done_cnt - d0, 1);

        // Three-instruction program.
        load(20'h0_05_03, 1'b1);
        load(20'h2_01_02, 1'b1);
        load(20'h8_00_04, 1'b1);
        sample();
        check("p3_count", 32'(count), 3);
        check("p3_idle_op", 32'(op), 0);
        address = 4'd0;
        ctrl_en = 1'b1;
        d0 = done_cnt;
        pulse_start();
        sample();
        check("p3_first_op", 32'(op), 1);
        check("p3_first_opcode", 32'(opcode), 32'h0);
        check("p3_first_b", 32'(operand_b), 32'h05);
        check("p3_first_a", 32'(operand_a), 32'h03);
        wait_done(200, ok);
        check("p3_done_seen", 32'(ok), 1);
        check("p3_queue_empty", exp_q.size(), 0);
        check("p3_count_kept", 32'(count), 3);
        sample();
        check("p3_done_drop", 32'(done), 0);
        check("p3_done_once", done_cnt - d0, 1);
        ctrl_en = 1'b0;

        // Stalled controller, then abort.
        address = 4'd0;
        exp_q.push_back(20'h0_05_03);
        d0 = done_cnt;
        pulse_start();
        high = 0;
        for (int i = 0; i < 50; i++) begin
            sample();
            if (op === 1'b1 && busy === 1'b1) high++;
        end
        check("stall_op_held", high, 50);
        abort = 1'b1;
        step();
        abort = 1'b0;
        sample();
        check("abort_op", 32'(op), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_count", 32'(count), 3);
        sample();
        check("abort_no_done", done_cnt - d0, 0);

        // Clear beats a simultaneous write.
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 20'hABCDE;
        sample();
        check("clear_wr_ready", 32'(wr_ready), 0);
        step();
        clear    = 1'b0;
        wr_valid = 1'b0;
        sample();
        check("clear_count", 32'(count), 0);

        // Write and start in the same cycle from an empty program.
        address  = 4'd0;
        ctrl_en  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 20'h3_7A_5C;
        exp_q.push_back(20'h3_7A_5C);
        start    = 1'b1;
        step();
        wr_valid = 1'b0;
        start    = 1'b0;
        sample();
        check("ws_busy", 32'(busy), 1);
        check("ws_count", 32'(count), 1);
        wait_done(100, ok);
        check("ws_done_seen", 32'(ok), 1);
        ctrl_en = 1'b0;

        // Full program of 16, overflow word dropped, address wraps.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = {4'(i), 8'(i * 17), 8'hF0 ^ 8'(i)};
            load(w, 1'b1);
        end
        sample();
        check("full_count", 32'(count), 16);
        check("full_wr_ready", 32'(wr_ready), 0);
        wr_valid = 1'b1;
        wr_data  = 20'hFFFFF;
        step();
        wr_valid = 1'b0;
        sample();
        check("full_drop_count", 32'(count), 16);
        address = 4'd0;
        ctrl_en = 1'b1;
        o0 = offers;
        d0 = done_cnt;
        pulse_start();
        wait_done(400, ok);
        check("full_done_seen", 32'(ok), 1);
        check("full_offers", offers - o0, 16);
        check("full_queue_empty", exp_q.size(), 0);
        sample();
        check("full_done_once", done_cnt - d0, 1);
        ctrl_en = 1'b0;

        // Reset during the gap after the second of three instructions.
        clear = 1'b1;
        step();
        clear = 1'b0;
        load(20'h1_11_22, 1'b1);
        load(20'h4_33_44, 1'b1);
        load(20'hF_FF_00, 1'b1);
        address = 4'd0;
        ctrl_en = 1'b1;
        o0 = offers;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sample();
            if (offers - o0 >= 2 && busy === 1'b1 && op === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_mid_reached_wait", 32'(got), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_op", 32'(op), 0);
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_busy", 32'(busy), 0);
        ctrl_en = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        sample();
        check("rst_rel_wr_ready", 32'(wr_ready), 1);
        check("rst_rel_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
